// File: rtl/mem_pkg.sv
// mem_pkg: shared arbiter state encoding and RISC-V load/store size codes.
package mem_pkg;
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} arb_state_t;
  localparam logic [2:0] SIZE_B  = 3'b000;
  localparam logic [2:0] SIZE_H  = 3'b001;
  localparam logic [2:0] SIZE_W  = 3'b010;
  localparam logic [2:0] SIZE_BU = 3'b100;
  localparam logic [2:0] SIZE_HU = 3'b101;
endpackage

// File: rtl/arb_timer.sv
// arb_timer: counts busy cycles without a memory ack and flags expiry at TIMEOUT.
module arb_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  // Expiry is the TIMEOUT-th stalled cycle, so the abort lands in that same cycle.
  assign expired_o = en_i && (cnt_q == LAST);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and load/store, data-first with bounded fetch starvation.
// Define ARB_TIMEOUT_EN to abort accesses that see no mem_ack within TIMEOUT busy cycles.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int ADDR_W         = 32,
  parameter int MAX_DATA_BURST = 4,
  parameter int TIMEOUT        = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              halted,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [XLEN-1:0]   if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  input  logic [2:0]        d_size,
  output logic              d_ready,
  output logic [XLEN-1:0]   d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [2:0]        mem_size,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              bus_err
);
  localparam int BW = $clog2(MAX_DATA_BURST + 1);
  localparam logic [BW-1:0] BMAX = BW'(MAX_DATA_BURST);
  arb_state_t        state_q, state_d;
  logic [BW-1:0]     burst_q, burst_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [2:0]        size_q, size_d;
  logic busy, in_i, in_d, done, free, if_cand, d_cand, fetch_first, grant_i, grant_d, expired;
`ifdef ARB_TIMEOUT_EN
  arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (grant_i | grant_d),
    .en_i     (busy & ~mem_ack),
    .expired_o(expired)
  );
`else
  localparam int unused_timeout = TIMEOUT;
  assign expired = 1'b0;
`endif
  always_comb begin
    busy        = state_q != IDLE;
    in_i        = state_q == BUSY_I;
    in_d        = state_q == BUSY_D;
    done        = busy & (mem_ack | expired);
    free        = ~busy | mem_ack;
    // The requester being completed still holds its req this cycle; that is not a new request.
    if_cand     = if_req & ~in_i;
    d_cand      = d_req & ~in_d;
    fetch_first = if_cand & (~d_cand | (burst_q == BMAX));
    grant_i     = free & ~halted & fetch_first;
    grant_d     = free & ~halted & d_cand & ~fetch_first;
    state_d     = grant_i ? BUSY_I : grant_d ? BUSY_D : done ? IDLE : state_q;
    burst_d     = (grant_i | ~if_req) ? '0 :
                  (grant_d & (burst_q != BMAX)) ? burst_q + BW'(1) : burst_q;
    addr_d      = grant_i ? if_addr : grant_d ? d_addr : addr_q;
    we_d        = grant_i ? 1'b0 : grant_d ? d_we : we_q;
    wdata_d     = grant_i ? '0 : grant_d ? d_wdata : wdata_q;
    size_d      = grant_i ? 3'b000 : grant_d ? d_size : size_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      burst_q <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
    end
  assign mem_req   = busy & ~expired;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_size  = size_q;
  assign if_ready  = in_i & done;
  assign d_ready   = in_d & done;
  assign if_rdata  = (in_i & mem_ack) ? mem_rdata : '0;
  assign d_rdata   = (in_d & mem_ack) ? mem_rdata : '0;
  assign bus_err   = expired;
endmodule
